// File: rtl/nor_bus_ctrl.sv
// NOR flash bus controller: Wishbone classic slave to an asynchronous
// parallel NOR device. A request runs SETUP -> STROBE -> HOLD, then RYWAIT
// if needed, then DONE. Every NOR-side output is driven from a flop.
module nor_bus_ctrl #(
   parameter int unsigned T_SETUP = 1,
   parameter int unsigned T_RD    = 4,
   parameter int unsigned T_WR    = 3,
   parameter int unsigned T_HOLD  = 1,
   parameter int unsigned RY_TO   = 1048575
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [25:0] wb_adr_i,
   input  logic [15:0] wb_dat_i,
   input  logic        wait_ry_i,
   output logic [15:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        busy_o,
   output logic [25:0] nor_addr_o,
   input  logic [15:0] nor_data_i,
   output logic [15:0] nor_data_o,
   output logic        nor_data_oe,
   output logic        nor_ce_o,
   output logic        nor_oe_o,
   output logic        nor_we_o,
   input  logic        nor_ry_i
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETUP  = 3'd1;
   localparam logic [2:0] S_STROBE = 3'd2;
   localparam logic [2:0] S_HOLD   = 3'd3;
   localparam logic [2:0] S_RYWAIT = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   // Terminal counts: the counter restarts at 0 on every state entry.
   localparam logic [19:0] C_SETUP = 20'(T_SETUP - 1);
   localparam logic [19:0] C_RD    = 20'(T_RD - 1);
   localparam logic [19:0] C_WR    = 20'(T_WR - 1);
   localparam logic [19:0] C_HOLD  = 20'(T_HOLD - 1);
   localparam logic [19:0] C_RYTO  = 20'(RY_TO - 1);

   logic [2:0]  r_state;
   logic [19:0] r_cnt;
   logic        r_we;
   logic        r_wait_ry;
   logic        r_abort;
   logic        r_seen_busy;
   logic        r_ry_meta;
   logic        r_ry_s;
   logic [25:0] r_addr;
   logic [15:0] r_dout;
   logic [15:0] r_dat;
   logic        r_doe;
   logic        r_ce;
   logic        r_oe;
   logic        r_wen;
   logic        r_ack;
   logic        r_err;
   logic        w_strobe_last;

   assign w_strobe_last = r_we ? (r_cnt == C_WR) : (r_cnt == C_RD);

   // Two-flop synchronizer for the asynchronous RY/BY pin.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_ry_meta <= 1'b0;
         r_ry_s    <= 1'b0;
      end else begin
         r_ry_meta <= nor_ry_i;
         r_ry_s    <= r_ry_meta;
      end
   end

   // Main sequencer: the NOR strobes, the data capture and the Wishbone
   // response are all registered here.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_we        <= 1'b0;
         r_wait_ry   <= 1'b0;
         r_abort     <= 1'b0;
         r_seen_busy <= 1'b0;
         r_addr      <= '0;
         r_dout      <= '0;
         r_dat       <= '0;
         r_doe       <= 1'b0;
         r_ce        <= 1'b1;
         r_oe        <= 1'b1;
         r_wen       <= 1'b1;
         r_ack       <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         // Master gave up: the NOR cycle still runs to completion, but no response.
         if (r_state != S_IDLE && !wb_cyc_i)
            r_abort <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (wb_cyc_i && wb_stb_i) begin
                  r_addr    <= wb_adr_i;
                  r_dout    <= wb_dat_i;
                  r_we      <= wb_we_i;
                  r_wait_ry <= wb_we_i & wait_ry_i;
                  r_abort   <= 1'b0;
                  r_ce      <= 1'b0;
                  r_doe     <= wb_we_i;
                  r_cnt     <= '0;
                  r_state   <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (r_cnt == C_SETUP) begin
                  r_cnt   <= '0;
                  r_state <= S_STROBE;
                  if (r_we) r_wen <= 1'b0;
                  else      r_oe  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 20'd1;
               end
            end
            S_STROBE: begin
               if (w_strobe_last) begin
                  r_cnt   <= '0;
                  r_oe    <= 1'b1;
                  r_wen   <= 1'b1;
                  r_state <= S_HOLD;
                  if (!r_we) r_dat <= nor_data_i;
               end else begin
                  r_cnt <= r_cnt + 20'd1;
               end
            end
            S_HOLD: begin
               if (r_cnt == C_HOLD) begin
                  r_cnt       <= '0;
                  r_ce        <= 1'b1;
                  r_doe       <= 1'b0;
                  r_seen_busy <= 1'b0;
                  if (r_wait_ry) begin
                     r_state <= S_RYWAIT;
                  end else begin
                     r_state <= S_DONE;
                     r_ack   <= wb_cyc_i & ~r_abort;
                  end
               end else begin
                  r_cnt <= r_cnt + 20'd1;
               end
            end
            S_RYWAIT: begin
               // One counter covers both the busy and the ready phase; a device
               // already busy on entry satisfies the busy phase immediately.
               if (!r_ry_s)
                  r_seen_busy <= 1'b1;
               if (r_seen_busy && r_ry_s) begin
                  r_state <= S_DONE;
                  r_ack   <= wb_cyc_i & ~r_abort;
               end else if (r_cnt == C_RYTO) begin
                  r_state <= S_DONE;
                  r_err   <= wb_cyc_i & ~r_abort;
               end else begin
                  r_cnt <= r_cnt + 20'd1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_ce    <= 1'b1;
               r_oe    <= 1'b1;
               r_wen   <= 1'b1;
               r_doe   <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o      = (r_state != S_IDLE);
   assign wb_dat_o    = r_dat;
   assign wb_ack_o    = r_ack;
   assign wb_err_o    = r_err;
   assign nor_addr_o  = r_addr;
   assign nor_data_o  = r_dout;
   assign nor_data_oe = r_doe;
   assign nor_ce_o    = r_ce;
   assign nor_oe_o    = r_oe;
   assign nor_we_o    = r_wen;

endmodule

// File: tb/tb_nor_bus_ctrl.sv
// Directed bench for nor_bus_ctrl: reads, writes, RY/BY wait, RY timeout,
// reset mid-cycle and a master that abandons a read.
module tb_nor_bus_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0, wait_ry = 1'b0;
   logic [25:0] wb_adr = '0;
   logic [15:0] wb_dat = '0;
   logic [15:0] wb_dat_o;
   logic        wb_ack, wb_err, busy;
   logic [25:0] nor_addr;
   logic [15:0] nor_din = '0;
   logic [15:0] nor_dout;
   logic        nor_doe, nor_ce, nor_oe, nor_wen;
   logic        nor_ry = 1'b1;

   int n_chk = 0;
   int n_fail = 0;

   // per-transaction observations
   int ack_k, err_k, ack_cnt, err_cnt, oe_cnt, we_cnt, doe_cnt, viol;
   logic [25:0]  addr_s;
   logic [15:0]  dout_s;
   logic [127:0] busy_h;

   always #5 clk = ~clk;

   nor_bus_ctrl #(.RY_TO(100)) dut (
      .clk_i(clk), .reset_i(rst),
      .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
      .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wait_ry_i(wait_ry),
      .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack), .wb_err_o(wb_err), .busy_o(busy),
      .nor_addr_o(nor_addr), .nor_data_i(nor_din), .nor_data_o(nor_dout),
      .nor_data_oe(nor_doe), .nor_ce_o(nor_ce), .nor_oe_o(nor_oe),
      .nor_we_o(nor_wen), .nor_ry_i(nor_ry)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one request and watch max_k edges, counting from the accept edge (k=1).
   // Entered #1 after a posedge. The master drops cyc/stb on ack/err.
   task automatic run(input logic we, input logic [25:0] adr, input logic [15:0] dat,
                      input logic wry, input int drop_k, input int req2_k,
                      input int rylo_k, input int ryhi_k, input int max_k);
      ack_k = 0; err_k = 0; ack_cnt = 0; err_cnt = 0;
      oe_cnt = 0; we_cnt = 0; doe_cnt = 0; viol = 0;
      addr_s = '0; dout_s = '0; busy_h = '0;
      wb_we = we; wb_adr = adr; wb_dat = dat; wait_ry = wry;
      wb_cyc = 1'b1; wb_stb = 1'b1;
      for (int k = 1; k <= max_k; k++) begin
         @(posedge clk); #1;
         busy_h[k] = busy;
         if (!nor_oe)  oe_cnt++;
         if (!nor_wen) we_cnt++;
         if (nor_doe)  doe_cnt++;
         if (!nor_oe && nor_doe) viol++;
         if (!nor_oe && !nor_wen) viol++;
         if (nor_doe && nor_ce)  viol++;
         if (k == 3) begin addr_s = nor_addr; dout_s = nor_dout; end
         if (wb_ack) begin
            ack_cnt++; if (ack_k == 0) ack_k = k;
            wb_cyc = 1'b0; wb_stb = 1'b0;
         end
         if (wb_err) begin
            err_cnt++; if (err_k == 0) err_k = k;
            wb_cyc = 1'b0; wb_stb = 1'b0;
         end
         if (k == drop_k) begin wb_cyc = 1'b0; wb_stb = 1'b0; end
         if (k == req2_k) begin wb_cyc = 1'b1; wb_stb = 1'b1; end
         if (k == rylo_k) nor_ry = 1'b0;
         if (k == ryhi_k) nor_ry = 1'b1;
      end
      wb_cyc = 1'b0; wb_stb = 1'b0; wait_ry = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      // reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ce", nor_ce, 1);
      chk("rst_oe", nor_oe, 1);
      chk("rst_we", nor_wen, 1);
      chk("rst_doe", nor_doe, 0);
      chk("rst_ack", wb_ack, 0);
      chk("rst_err", wb_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_addr", nor_addr, 0);
      chk("rst_dat", wb_dat_o, 0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // plain read
      nor_din = 16'hBEEF;
      run(1'b0, 26'h155AA, 16'h0000, 1'b0, 0, 0, 0, 0, 10);
      chk("rd_ack_k", ack_k, 7);
      chk("rd_ack_cnt", ack_cnt, 1);
      chk("rd_oe_cnt", oe_cnt, 4);
      chk("rd_we_cnt", we_cnt, 0);
      chk("rd_doe_cnt", doe_cnt, 0);
      chk("rd_data", wb_dat_o, 16'hBEEF);
      chk("rd_addr", addr_s, 26'h155AA);
      chk("rd_viol", viol, 0);
      chk("rd_busy_end", busy, 0);

      // plain write
      run(1'b1, 26'h0AAA, 16'h0055, 1'b0, 0, 0, 0, 0, 10);
      chk("wr_ack_k", ack_k, 6);
      chk("wr_ack_cnt", ack_cnt, 1);
      chk("wr_we_cnt", we_cnt, 3);
      chk("wr_oe_cnt", oe_cnt, 0);
      chk("wr_doe_cnt", doe_cnt, 5);
      chk("wr_dout", dout_s, 16'h0055);
      chk("wr_addr", addr_s, 26'h0AAA);
      chk("wr_viol", viol, 0);

      // wait_ry is ignored on a read
      nor_din = 16'h1234;
      run(1'b0, 26'h0001, 16'h0000, 1'b1, 0, 0, 0, 0, 10);
      chk("rdry_ack_k", ack_k, 7);
      chk("rdry_data", wb_dat_o, 16'h1234);

      // write with RY/BY wait: busy at k=11, ready at k=51
      run(1'b1, 26'h0100, 16'hA5A5, 1'b1, 0, 0, 11, 51, 60);
      chk("ry_ack_k", ack_k, 54);
      chk("ry_ack_cnt", ack_cnt, 1);
      chk("ry_err_cnt", err_cnt, 0);
      chk("ry_ce_rywait", busy_h[30], 1);
      chk("ry_viol", viol, 0);

      // RY never goes busy: timeout after 100 RYWAIT cycles
      run(1'b1, 26'h0200, 16'h5A5A, 1'b1, 0, 0, 0, 0, 112);
      chk("to_err_k", err_k, 106);
      chk("to_err_cnt", err_cnt, 1);
      chk("to_ack_cnt", ack_cnt, 0);

      // reset during STROBE of a write
      wb_we = 1'b1; wb_adr = 26'h0003; wb_dat = 16'h1111; wait_ry = 1'b0;
      wb_cyc = 1'b1; wb_stb = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("mrst_pre_we", nor_wen, 0);
      rst = 1'b1;
      #1;
      chk("mrst_ce", nor_ce, 1);
      chk("mrst_we", nor_wen, 1);
      chk("mrst_doe", nor_doe, 0);
      chk("mrst_busy", busy, 0);
      wb_cyc = 1'b0; wb_stb = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      n = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (wb_ack) n++;
      end
      chk("mrst_no_ack", n, 0);
      nor_din = 16'h1357;
      run(1'b0, 26'h002A, 16'h0000, 1'b0, 0, 0, 0, 0, 10);
      chk("mrst_next_ack_k", ack_k, 7);
      chk("mrst_next_data", wb_dat_o, 16'h1357);

      // cyc dropped in SETUP, new request raised during DONE
      nor_din = 16'h2468;
      run(1'b0, 26'h0033, 16'h0000, 1'b0, 1, 7, 0, 0, 18);
      chk("drop_oe_cnt", oe_cnt, 8);
      chk("drop_busy7", busy_h[7], 1);
      chk("drop_busy8", busy_h[8], 0);
      chk("drop_busy9", busy_h[9], 1);
      chk("drop_ack_k", ack_k, 15);
      chk("drop_ack_cnt", ack_cnt, 1);
      chk("drop_data", wb_dat_o, 16'h2468);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
